ps2_key_events: RTL and testbench



---
 rtl/ps2_key_events.sv | 150 +++++++++++++++
 tb/tb_ps2_key_events.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_events.sv
// PS/2 set-2 scan-code to per-key event decoder.
// Tracks E0/F0 prefixes, keeps per-key held state and drives each key output
// in level, press-pulse, typematic-repeat or toggle mode.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ps2_byte    - received byte, qualified by ps2_valid
//   ps2_valid   - one-cycle strobe per received byte
//   clr         - synchronous clear of all key state and the prefix FSM
//   keys        - per-key output, meaning set by KEY_MODES
//   held        - per-key physical held state
module ps2_key_events #(
  parameter int unsigned NUM_KEYS      = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {9'h05A, 9'h029, 9'h172, 9'h175},
  parameter logic [63:0] KEY_MODES     = 64'h0000_0000_0000_00DA,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          ps2_byte,
  input  logic                ps2_valid,
  input  logic                clr,
  output logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] held
);

  localparam int unsigned CODE_W = 9;
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              ev_valid;
  logic              ev_brk;
  logic [CODE_W-1:0] ev_code;

  logic [NUM_KEYS-1:0] held_d, keys_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  // Bytes that carry no key information (ACK, BAT, echo, resend, errors, pause prefix).
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: is_discard = 1'b1;
      default:                                         is_discard = 1'b0;
    endcase
  endfunction

  // Prefix state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Prefix next-state; an E0 always restarts an extended sequence.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (ps2_valid) begin
      if (ps2_byte == 8'hE0) begin
        state_d = ST_EXT;
      end else if (ps2_byte == 8'hF0) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Event decode from the current prefix state and the incoming byte.
  always_comb begin
    ev_valid = 1'b0;
    ev_brk   = 1'b0;
    ev_code  = '0;
    if (ps2_valid && !clr && ps2_byte != 8'hE0 && ps2_byte != 8'hF0 && !is_discard(ps2_byte)) begin
      ev_valid = 1'b1;
      ev_brk   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
      ev_code  = {(state_q == ST_EXT) || (state_q == ST_EXT_BRK), ps2_byte};
    end
  end

  // Per-key held/output/repeat next state.
  always_comb begin
    held_d = held;
    keys_d = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      logic hit, mk, bk, press;
      hit   = ev_valid && (KEY_CODES[CODE_W*i +: CODE_W] == ev_code);
      mk    = hit && !ev_brk;
      bk    = hit && ev_brk;
      press = mk && !held[i];
      if (mk)      held_d[i] = 1'b1;
      else if (bk) held_d[i] = 1'b0;
      cnt_d[i] = '0;
      case (KEY_MODES[2*i +: 2])
        2'd0: keys_d[i] = held_d[i];
        2'd1: keys_d[i] = press;
        2'd2: begin
          // Break takes priority over a repeat pulse due in the same cycle.
          if (press) begin
            keys_d[i] = 1'b1;
            cnt_d[i]  = DELAY_LD;
          end else if (bk || !held[i]) begin
            cnt_d[i]  = '0;
          end else if (cnt_q[i] == CNT_ONE) begin
            keys_d[i] = 1'b1;
            cnt_d[i]  = PERIOD_LD;
          end else if (cnt_q[i] != '0) begin
            cnt_d[i]  = cnt_q[i] - CNT_ONE;
          end
        end
        default: keys_d[i] = keys[i] ^ press;
      endcase
      if (clr) begin
        held_d[i] = 1'b0;
        keys_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end
    end
  end

  // Per-key state registers; outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
      keys <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      held <= held_d;
      keys <= keys_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_ps2_key_events.sv
// Directed bench for ps2_key_events with a short typematic timing.
// Expected {keys, held} values are queued as each step is driven and
// compared one clock edge later when the DUT has produced them.
module tb_ps2_key_events;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] keys;
  logic [3:0] held;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  ps2_key_events #(
    .NUM_KEYS(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps2_byte(ps2_byte),
    .ps2_valid(ps2_valid),
    .clr(clr),
    .keys(keys),
    .held(held)
  );

  always #5 clk = ~clk;

  task automatic compare();
    logic [7:0] exp;
    string t;
    exp = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert ({keys, held} === exp)
      else begin
        errors++;
        $error("FAIL %s keys,held=%b required %b", t, {keys, held}, exp);
      end
  endtask

  task automatic expect_now(input logic [3:0] ek, input logic [3:0] eh, input string t);
    exp_q.push_back({ek, eh});
    tag_q.push_back(t);
    compare();
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic c,
                      input logic [3:0] ek, input logic [3:0] eh, input string t);
    ps2_valid = v;
    ps2_byte  = b;
    clr       = c;
    exp_q.push_back({ek, eh});
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    ps2_valid = 1'b0;
    ps2_byte  = 8'h00;
    clr       = 1'b0;
    compare();
  endtask

  task automatic idle(input logic [3:0] ek, input logic [3:0] eh, input string t);
    step(1'b0, 8'h00, 1'b0, ek, eh, t);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_now(4'b0000, 4'b0000, "reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_now(4'b0000, 4'b0000, "post_reset");

    // Key2 press pulse, repeated make while held, break.
    step(1'b1, 8'h29, 1'b0, 4'b0100, 4'b0100, "k2_press");
    idle(4'b0000, 4'b0100, "k2_pulse_end");
    step(1'b1, 8'h29, 1'b0, 4'b0000, 4'b0100, "k2_repeat_make");
    step(1'b1, 8'hF0, 1'b0, 4'b0000, 4'b0100, "k2_f0");
    step(1'b1, 8'h29, 1'b0, 4'b0000, 4'b0000, "k2_break");
    idle(4'b0000, 4'b0000, "k2_idle");

    // Extended-only key must not match a plain code.
    step(1'b1, 8'h75, 1'b0, 4'b0000, 4'b0000, "plain_75");
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, "e0");
    step(1'b1, 8'h75, 1'b0, 4'b0001, 4'b0001, "k0_press");
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0001, "k0_e0");
    step(1'b1, 8'hF0, 1'b0, 4'b0000, 4'b0001, "k0_f0");
    step(1'b1, 8'h75, 1'b0, 4'b0000, 4'b0000, "k0_break");

    // Typematic: press, pulses at +10 then every 4, break lands on a due pulse.
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, "rep_e0");
    step(1'b1, 8'h75, 1'b0, 4'b0001, 4'b0001, "rep_press");
    for (int j = 1; j <= 27; j++)
      idle((j >= 10 && (j - 10) % 4 == 0) ? 4'b0001 : 4'b0000, 4'b0001, $sformatf("rep_j%0d", j));
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0001, "rep_brk_e0");
    step(1'b1, 8'hF0, 1'b0, 4'b0000, 4'b0001, "rep_brk_f0");
    step(1'b1, 8'h75, 1'b0, 4'b0000, 4'b0000, "rep_break_wins");
    for (int j = 0; j < 10; j++) idle(4'b0000, 4'b0000, "rep_after_break");

    // Key3 toggle.
    step(1'b1, 8'h5A, 1'b0, 4'b1000, 4'b1000, "k3_tog_on");
    step(1'b1, 8'hF0, 1'b0, 4'b1000, 4'b1000, "k3_f0");
    step(1'b1, 8'h5A, 1'b0, 4'b1000, 4'b0000, "k3_break_keep");
    step(1'b1, 8'h5A, 1'b0, 4'b0000, 4'b1000, "k3_tog_off");
    step(1'b1, 8'hF0, 1'b0, 4'b0000, 4'b1000, "k3_f0b");
    step(1'b1, 8'h5A, 1'b0, 4'b0000, 4'b0000, "k3_break2");

    // Discard byte resets the prefix; E0 after F0 restarts the sequence.
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, "fa_e0");
    step(1'b1, 8'hFA, 1'b0, 4'b0000, 4'b0000, "fa_discard");
    step(1'b1, 8'h75, 1'b0, 4'b0000, 4'b0000, "fa_75_plain");
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, "rs_e0");
    step(1'b1, 8'hF0, 1'b0, 4'b0000, 4'b0000, "rs_f0");
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, "rs_e0b");
    step(1'b1, 8'h72, 1'b0, 4'b0010, 4'b0010, "k1_press");

    // Clear while key1 repeats; the same-cycle byte is dropped.
    for (int j = 1; j <= 11; j++)
      idle((j == 10) ? 4'b0010 : 4'b0000, 4'b0010, $sformatf("k1_j%0d", j));
    step(1'b1, 8'h5A, 1'b1, 4'b0000, 4'b0000, "clr_wins");
    for (int j = 0; j < 15; j++) idle(4'b0000, 4'b0000, "after_clr");

    // Async reset while key1 repeats and an E0 prefix is pending.
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0000, "k1b_e0");
    step(1'b1, 8'h72, 1'b0, 4'b0010, 4'b0010, "k1b_press");
    for (int j = 1; j <= 10; j++)
      idle((j == 10) ? 4'b0010 : 4'b0000, 4'b0010, $sformatf("k1b_j%0d", j));
    step(1'b1, 8'hE0, 1'b0, 4'b0000, 4'b0010, "pre_rst_e0");
    #2 rst_n = 1'b0;
    #1 expect_now(4'b0000, 4'b0000, "async_rst");
    @(posedge clk); #1;
    expect_now(4'b0000, 4'b0000, "rst_held");
    #2 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 8'h75, 1'b0, 4'b0000, 4'b0000, "prefix_dropped");
    for (int j = 0; j < 12; j++) idle(4'b0000, 4'b0000, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
